// File: rtl/display_restador_if.sv
// Bus between the subtractor side and the display stage: captured operand
// and load strobe in, multiplexed seven-segment drive and sign flag out.
interface display_restador_if;
  logic [2:0] F;
  logic       carga;
  logic [6:0] seg;
  logic [1:0] an;
  logic       neg;

  modport master (
    output F,
    output carga,
    input  seg,
    input  an,
    input  neg
  );

  modport slave (
    input  F,
    input  carga,
    output seg,
    output an,
    output neg
  );
endinterface

// File: rtl/display_restador.sv
// Display stage for the 3-bit subtractor: latches the result on a load
// strobe, splits it into sign and magnitude, and scans both digits of a
// common-anode seven-segment display with a blanking slot between digits.
module display_restador #(
  parameter int DIV = 50000
) (
  input logic               clk,
  input logic               rst,
  display_restador_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    DIG0,
    BLK0,
    DIG1,
    BLK1
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   presc;
  logic [2:0]      dato;
  logic [2:0]      mag;
  logic [6:0]      mag_code;
  logic [6:0]      sign_code;

  // Capture the subtractor result only when the load strobe is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dato <= 3'b000;
    end else if (bus.carga) begin
      dato <= bus.F;
    end
  end

  // Sign flag follows the captured value one edge later, like the digits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.neg <= 1'b0;
    end else begin
      bus.neg <= dato[2];
    end
  end

  // Two's complement to sign/magnitude, then to active-low segment patterns
  always_comb begin
    mag       = dato[2] ? (~dato + 3'd1) : dato;
    sign_code = dato[2] ? SEG_DASH : SEG_BLANK;
    case (mag)
      3'd0:    mag_code = 7'b1000000;
      3'd1:    mag_code = 7'b1111001;
      3'd2:    mag_code = 7'b0100100;
      3'd3:    mag_code = 7'b0110000;
      3'd4:    mag_code = 7'b0011001;
      default: mag_code = SEG_BLANK;
    endcase
  end

  // Digit states leave at the prescaler terminal count, blanking slots after one cycle
  always_comb begin
    next_state = state;
    case (state)
      DIG0:    if (presc == TERM) next_state = BLK0;
      BLK0:    next_state = DIG1;
      DIG1:    if (presc == TERM) next_state = BLK1;
      BLK1:    next_state = DIG0;
      default: next_state = DIG0;
    endcase
  end

  // Scan FSM; outputs are loaded from the state being entered so they track it exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BLK1;
      presc   <= '0;
      bus.seg <= SEG_BLANK;
      bus.an  <= 2'b11;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        presc <= '0;
      end else begin
        presc <= presc + CW'(1);
      end
      case (next_state)
        DIG0: begin
          bus.an  <= 2'b10;
          bus.seg <= mag_code;
        end
        DIG1: begin
          bus.an  <= 2'b01;
          bus.seg <= sign_code;
        end
        default: begin
          bus.an  <= 2'b11;
          bus.seg <= SEG_BLANK;
        end
      endcase
    end
  end

endmodule

// File: doc/display_restador.md
# display_restador

Downstream display stage for the 3-bit subtractor. It captures the subtractor result `F` on a load strobe and interprets it as 3-bit two's complement (−4..+3). It then drives a 2-digit, time-multiplexed, common-anode seven-segment display: left digit shows sign, right digit shows magnitude. A scan FSM inserts a one-cycle blanking slot between digits to suppress ghosting.

## Interface
- `DIV`, default 50000, clock cycles each digit stays lit (≥1; 50000 ≈ 1 kHz per digit at 50 MHz)
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-high
- `F`  in  3  subtractor result, two's complement
- `carga`  in  1  load strobe; `F` sampled on the rising edge where `carga`=1
- `seg`  out  7  segments, active-low, `seg[6:0]` = g,f,e,d,c,b,a
- `an`  out  2  digit enables, active-low; `an[0]` = right (magnitude), `an[1]` = left (sign)
- `neg`  out  1  captured value is negative

## Operation
- Value register `dato[2:0]`:
  - loads `F` when `carga`=1;
  - holds otherwise;
  - `F` changes without `carga` have no effect.
- Sign/magnitude decode from `dato`:
  - `dato[2]`=0 → magnitude = `dato` (0..3), sign digit blank;
  - `dato[2]`=1 → magnitude = (~`dato`+1) in 3 bits, values 1..4 (`3'b100` → 4), sign digit '-'.
- Segment codes, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - '-'=0111111, blank=1111111
- Scan FSM states: DIG0 → BLK0 → DIG1 → BLK1 → DIG0.
  - DIG0: `an`=10, `seg`=magnitude code.
  - DIG1: `an`=01, `seg`=sign code.
  - BLK0/BLK1: `an`=11, `seg`=1111111.
  - A DIG state lasts exactly `DIV` cycles (prescaler counts 0..DIV−1; leaves at terminal count). A BLK state lasts exactly 1 cycle. Scan period = 2·(DIV+1) cycles.
  - Prescaler clears on every state change. Width = max(1, $clog2(DIV)).
- `carga` is accepted in any FSM state and never alters state or prescaler.
- `seg`, `an`, `neg` are registered outputs. No combinational path from inputs to outputs.

## Timing
- During `rst`=1, asynchronous and immediate:
  - `dato`=000, FSM=BLK1, prescaler=0
  - `seg`=1111111, `an`=11, `neg`=0
- First rising edge after `rst` falls: FSM enters DIG0; `an`=10, `seg`=1000000 (shows 0).
- Capture latency: `carga` sampled at edge k → `dato` valid after k; `neg` and `seg` reflect the new value from edge k+1 while in a DIG state. In a BLK state, `seg` stays blank.
- Output registers are updated at the same edge as the FSM state, so `an`/`seg` always match the current state.
- Reset mid-scan, at any state or prescaler value: outputs return to their reset values without waiting for a clock edge. The captured value is lost.
- `DIV`=1: DIG states last one cycle; scan period = 4.

## Test plan
- Reset: hold `rst`=1 for 3 cycles → `seg`=1111111, `an`=11, `neg`=0. Release → after the next edge, `an`=10, `seg`=1000000.
- Negative value, `DIV`=2: `F`=3'd7, `carga` pulse → `neg`=1; right digit `seg`=1111001 ("1"); left digit `seg`=0111111 ('-').
- Boundary magnitudes:
  - `F`=3'd4 → right digit `seg`=0011001 ("4"), left '-', `neg`=1
  - `F`=3'd3 → right digit 0110000 ("3"), left blank, `neg`=0
  - `F`=3'd0 → right digit 1000000 ("0"), left blank, `neg`=0
- Scan sequence, `DIV`=2, no loads → `an` per cycle = 10,10,11,01,01,11, repeating. `seg`=1111111 whenever `an`=11.
- Hold behaviour: load `F`=3'd2, then drive `F`=3'd6 with `carga`=0 for 20 cycles → display stays "2", left blank, `neg`=0. A `carga` pulse during a BLK cycle → new value shown from the next DIG state, scan phase unchanged.
- Reset mid-operation: assert `rst` during DIG1, mid-prescaler → `seg`=1111111, `an`=11, `neg`=0 before the next clock edge. After release: DIG0 showing "0".
